// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared async FIFO constants and clog2 helper
//
// Purpose : constants common to rd_logic, wr_logic and the read-side FWFT stage.
// Contents: FIFO_DATA_WIDTH  default word width
//           ADDR_WIDTH       FIFO memory address width
//           PTR_WIDTH        FIFO gray/binary pointer width (address + wrap bit)
//           clog2()          ceiling log2, usable in parameter/port declarations
package fifo_pkg;

   localparam int FIFO_DATA_WIDTH = 8;
   localparam int ADDR_WIDTH      = 4;
   localparam int PTR_WIDTH       = 5;

   // Smallest r with 2**r >= value; clog2(1) = 0.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/fifo_rd_fwft.sv
// rtl/fifo_rd_fwft.sv - read-side first-word-fall-through output stage
//
// Purpose : turns the FIFO rd_en/empty port (sync memory, data one cycle after an
//           accepted read) into a valid/ready stream, prefetching into a small
//           register buffer so the head word is presented without a request.
// Ports   : rd_clk      read-domain clock
//           rd_rst      asynchronous active-high reset
//           fifo_empty  rd_logic empty flag
//           fifo_rd_en  read request to rd_logic / memory
//           fifo_rdata  memory data, valid the cycle after an accepted fifo_rd_en
//           m_valid     head word available
//           m_data      head word (0 while m_valid=0)
//           m_ready     downstream accept; transfer = m_valid & m_ready
//           buf_level   words currently held in the output buffer
module fifo_rd_fwft
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
   parameter int OUT_DEPTH  = 3
) (
   input  logic                               rd_clk,
   input  logic                               rd_rst,
   input  logic                               fifo_empty,
   output logic                               fifo_rd_en,
   input  logic [DATA_WIDTH-1:0]              fifo_rdata,
   output logic                               m_valid,
   output logic [DATA_WIDTH-1:0]              m_data,
   input  logic                               m_ready,
   output logic [clog2(OUT_DEPTH+1)-1:0]      buf_level
);

   localparam int LVL_W = clog2(OUT_DEPTH + 1);
   localparam int PTR_W = clog2(OUT_DEPTH);
   localparam int OCC_W = LVL_W + 1;

   logic [DATA_WIDTH-1:0] r_slot [OUT_DEPTH];
   logic [PTR_W-1:0]      r_head;
   logic [PTR_W-1:0]      r_tail;
   logic [LVL_W-1:0]      r_level;
   logic                  r_inflight;

   logic                  w_push;
   logic                  w_pop;
   logic [OCC_W-1:0]      w_occupied;

   // Explicit wrap so OUT_DEPTH need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Credit check counts the word already requested but not yet landed, so a
   // push can never find the buffer full. Only registered state and fifo_empty
   // feed the request; m_ready has no combinational path to fifo_rd_en.
   assign w_occupied = OCC_W'(r_level) + OCC_W'(r_inflight);
   assign fifo_rd_en = ~fifo_empty & ~rd_rst & (w_occupied < OCC_W'(OUT_DEPTH));

   assign m_valid    = (r_level != '0);
   assign m_data     = m_valid ? r_slot[r_head] : '0;
   assign buf_level  = r_level;

   assign w_push     = r_inflight;
   assign w_pop      = m_valid & m_ready;

   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
         r_head     <= '0;
         r_tail     <= '0;
         r_level    <= '0;
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= fifo_rd_en;
         if (w_push) begin
            r_tail <= ptr_inc(r_tail);
         end
         if (w_pop) begin
            r_head <= ptr_inc(r_head);
         end
         r_level <= r_level + LVL_W'(w_push) - LVL_W'(w_pop);
      end
   end

   // Data slots carry no reset; a word in flight at reset is dropped because
   // r_inflight is cleared.
   always_ff @(posedge rd_clk) begin
      if (w_push) begin
         r_slot[r_tail] <= fifo_rdata;
      end
   end

   a_no_overflow: assert property (@(posedge rd_clk) disable iff (rd_rst)
      !(w_push && (r_level == LVL_W'(OUT_DEPTH))));

endmodule

// File: tb/tb_fifo_rd_fwft.sv
// tb/tb_fifo_rd_fwft.sv - scoreboard testbench for fifo_rd_fwft
module tb_fifo_rd_fwft;

   localparam int DW    = 8;
   localparam int DEPTH = 3;

   logic          rd_clk = 1'b0;
   logic          rd_rst = 1'b1;
   logic          fifo_empty;
   logic          fifo_rd_en;
   logic [DW-1:0] fifo_rdata = '0;
   logic          m_valid;
   logic [DW-1:0] m_data;
   logic          m_ready = 1'b0;
   logic [1:0]    buf_level;

   logic          empty2;
   logic          rd_en2;
   logic [DW-1:0] rdata2 = '0;
   logic          m_valid2;
   logic [DW-1:0] m_data2;
   logic [1:0]    level2;
   logic          run2 = 1'b0;
   logic [DW-1:0] src2 = '0;

   always #5 rd_clk = ~rd_clk;

   fifo_rd_fwft #(.DATA_WIDTH(DW), .OUT_DEPTH(DEPTH)) u_dut (
      .rd_clk     (rd_clk),
      .rd_rst     (rd_rst),
      .fifo_empty (fifo_empty),
      .fifo_rd_en (fifo_rd_en),
      .fifo_rdata (fifo_rdata),
      .m_valid    (m_valid),
      .m_data     (m_data),
      .m_ready    (m_ready),
      .buf_level  (buf_level)
   );

   fifo_rd_fwft #(.DATA_WIDTH(DW), .OUT_DEPTH(2)) u_dut2 (
      .rd_clk     (rd_clk),
      .rd_rst     (rd_rst),
      .fifo_empty (empty2),
      .fifo_rd_en (rd_en2),
      .fifo_rdata (rdata2),
      .m_valid    (m_valid2),
      .m_data     (m_data2),
      .m_ready    (1'b1),
      .buf_level  (level2)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Source FIFO model: sync-read memory, data one cycle after rd_en.
   logic [DW-1:0] mem [1024];
   int            wr_idx = 0;
   int            rd_idx = 0;
   logic [DW-1:0] exp_q [$];

   assign fifo_empty = (rd_idx == wr_idx);

   always @(posedge rd_clk) begin
      if (rd_rst) begin
         rd_idx <= 0;
      end else if (fifo_rd_en) begin
         fifo_rdata <= mem[rd_idx[9:0]];
         rd_idx     <= rd_idx + 1;
      end
   end

   // Endless source for the depth-2 instance.
   assign empty2 = ~run2;
   always @(posedge rd_clk) begin
      if (rd_rst) begin
         src2 <= '0;
      end else if (rd_en2) begin
         rdata2 <= src2;
         src2   <= src2 + 8'd1;
      end
   end

   task automatic push_word(input logic [DW-1:0] w);
      mem[wr_idx[9:0]] = w;
      wr_idx++;
      exp_q.push_back(w);
   endtask

   task automatic step();
      @(posedge rd_clk);
      #1;
   endtask

   task automatic drain(input int bound);
      for (int i = 0; i < bound && exp_q.size() != 0; i++) step();
      chk("drain_timeout", exp_q.size(), 0);
   endtask

   // Monitor: level/request model plus scoreboard pops, sampled at negedge.
   int            mdl_lvl = 0;
   bit            en_d1 = 0, en_d2 = 0, xfer_d1 = 0, hold = 0;
   logic [DW-1:0] hold_data = '0;
   int            simul_cnt = 0;

   always @(negedge rd_clk) begin
      if (rd_rst) begin
         chk("rd_en_in_reset", fifo_rd_en, 0);
         mdl_lvl = 0; en_d1 = 0; en_d2 = 0; xfer_d1 = 0; hold = 0;
      end else begin
         if (en_d2 && xfer_d1) simul_cnt++;
         mdl_lvl = mdl_lvl + int'(en_d2) - int'(xfer_d1);
         chk("buf_level", buf_level, mdl_lvl);
         chk("m_valid", m_valid, int'(mdl_lvl != 0));
         chk("fifo_rd_en", fifo_rd_en,
             int'(!fifo_empty && (mdl_lvl + int'(en_d1) < DEPTH)));
         if (hold) begin
            chk("hold_valid", m_valid, 1);
            chk("hold_data", m_data, hold_data);
         end
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) chk("scoreboard_empty_on_xfer", 0, 1);
            else chk("m_data", m_data, exp_q.pop_front());
         end
         en_d2     = en_d1;
         en_d1     = fifo_rd_en;
         xfer_d1   = m_valid && m_ready;
         hold      = m_valid && !m_ready;
         hold_data = m_data;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt, first, last, nxt2, last2;

      // Reset state
      repeat (2) @(posedge rd_clk);
      @(negedge rd_clk);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_buf_level", buf_level, 0);
      chk("rst_rd_en", fifo_rd_en, 0);
      chk("rst_m_data", m_data, 0);
      step();
      rd_rst = 1'b0;

      // FWFT latency and stability under m_ready=0
      step();
      push_word(8'hA5);
      @(negedge rd_clk); chk("fwft_rd_en_c0", fifo_rd_en, 1);
      step();
      @(negedge rd_clk); chk("fwft_rd_en_c1", fifo_rd_en, 0); chk("fwft_valid_c1", m_valid, 0);
      step();
      @(negedge rd_clk); chk("fwft_valid_c2", m_valid, 1); chk("fwft_data_c2", m_data, 8'hA5);
      repeat (10) step();
      m_ready = 1'b1;
      step();
      @(negedge rd_clk); chk("fwft_valid_after_pop", m_valid, 0);
      m_ready = 1'b0;

      // Backpressure: 8 queued, only 3 reads issued
      step();
      for (int i = 0; i < 8; i++) push_word(8'h40 + 8'(i));
      cnt = 0;
      repeat (12) begin
         @(negedge rd_clk);
         if (fifo_rd_en) cnt++;
         step();
      end
      chk("bp_reads_issued", cnt, 3);
      @(negedge rd_clk);
      chk("bp_level", buf_level, 3);
      chk("bp_rd_en", fifo_rd_en, 0);
      step();
      m_ready = 1'b1;
      drain(100);
      m_ready = 1'b0;

      // Reset mid-stream with buf_level=2 and a read in flight
      step();
      for (int i = 0; i < 4; i++) push_word(8'h50 + 8'(i));
      repeat (3) step();
      @(negedge rd_clk);
      chk("mid_level_before_rst", buf_level, 2);
      #1;
      rd_rst = 1'b1;
      wr_idx = 0;
      exp_q.delete();
      #1;
      chk("mid_rst_valid", m_valid, 0);
      chk("mid_rst_level", buf_level, 0);
      chk("mid_rst_rd_en", fifo_rd_en, 0);
      step();
      @(negedge rd_clk);
      chk("mid_rst_level_next", buf_level, 0);
      chk("mid_rst_valid_next", m_valid, 0);
      step();
      rd_rst = 1'b0;
      push_word(8'h3C);
      m_ready = 1'b1;
      drain(20);

      // Streaming 16 words, one per cycle after fill
      step();
      for (int i = 0; i < 16; i++) push_word(8'(i));
      cnt = 0; first = -1; last = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge rd_clk);
         if (m_valid && m_ready) begin
            if (first < 0) first = i;
            last = i;
            cnt++;
         end
         step();
      end
      chk("stream_count", cnt, 16);
      chk("stream_span", last - first, 15);
      chk("stream_scoreboard_empty", exp_q.size(), 0);

      // Random backpressure, 200 words
      for (int i = 0; i < 200; i++) push_word(8'((i * 37 + 11) & 255));
      for (int i = 0; i < 3000 && exp_q.size() != 0; i++) begin
         step();
         m_ready = 1'($urandom_range(0, 1));
      end
      chk("random_drain", exp_q.size(), 0);
      chk("push_pop_same_cycle_seen", int'(simul_cnt > 0), 1);
      m_ready = 1'b0;

      // Depth-2 instance, m_ready tied high
      step();
      run2 = 1'b1;
      cnt = 0; nxt2 = 0; last2 = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge rd_clk);
         chk("d2_level_bound", int'(level2 <= 2), 1);
         if (m_valid2) begin
            chk("d2_data", m_data2, nxt2 & 255);
            if (last2 >= 0) chk("d2_gap", int'((i - last2) <= 2), 1);
            nxt2++;
            last2 = i;
            cnt++;
         end
         step();
      end
      chk("d2_rate", int'(cnt >= 19), 1);
      run2 = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
